multicycle_controller: RTL and testbench
========================================

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 CNT_W, 16, width of retired-instruction counter.
REQ-002 clk  input  1  single clock, all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 run  input  1  level enable; a new instruction starts only while high.
REQ-005 Op  input  6  opcode field of the datapath instruction register.
REQ-006 Function  input  6  funct field of the datapath instruction register.
REQ-007 Zero  input  1  ALU result-equals-zero flag.
REQ-008 IorD  output  1  memory address select: 0 PC, 1 ALUOut.
REQ-009 MemRead  output  1  memory read enable.
REQ-010 MemWrite  output  1  memory write enable.
REQ-011 MemtoReg  output  1  register write data: 0 ALUOut, 1 MDR.
REQ-012 IRWrite  output  1  instruction register load.
REQ-013 PCSource  output  1  PC source: 0 ALUResult, 1 ALUOut.
REQ-014 ALUSrcA  output  1  ALU A operand: 0 PC, 1 A.
REQ-015 ALUSrcB  output  2  ALU B operand: 00 B, 01 constant 1, 10 sign-extended immediate.
REQ-016 RegWrite  output  1  register file write enable.
REQ-017 RegDst  output  1  destination: 0 rt, 1 rd.
REQ-018 PCSel  output  1  PC write enable.
REQ-019 ALUCtrl  output  4  ALU op: 0000 and, 0001 or, 0010 add, 0110 sub, 0111 slt, 1100 nor.
REQ-020 halted  output  1  high while in HALT.
REQ-021 state  output  4  current state encoding, for debug.
REQ-022 instr_count  output  CNT_W  retired-instruction count.

Function
REQ-023 States: IDLE, FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, REXEC, RWB, BRANCH, IEXEC, IWB, HALT. Control outputs are decoded from the registered state; any output not listed for a state is 0.
REQ-024 IDLE -> FETCH when run=1, otherwise stay in IDLE.
REQ-025 FETCH: MemRead=1, IorD=0, IRWrite=1, ALUSrcA=0, ALUSrcB=01, ALUCtrl=0010, PCSource=0, PCSel=1. Next state is always DECODE.
REQ-026 DECODE: ALUSrcA=0, ALUSrcB=10, ALUCtrl=0010, so ALUOut holds the branch target PC+1+imm.
REQ-026a DECODE next state by Op: 0x23 or 0x2B -> MEMADR; 0x00 with legal funct -> REXEC; 0x04 -> BRANCH; 0x08 -> IEXEC; anything else -> HALT.
REQ-027 MEMADR: ALUSrcA=1, ALUSrcB=10, ALUCtrl=0010. Next state is MEMRD if Op=0x23, else MEMWR.
REQ-028 MEMRD: MemRead=1, IorD=1, then MEMWB. MEMWB: RegWrite=1, RegDst=0, MemtoReg=1.
REQ-029 MEMWR: MemWrite=1, IorD=1.
REQ-030 REXEC: ALUSrcA=1, ALUSrcB=00, ALUCtrl from funct (0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x2A slt, 0x27 nor), then RWB. RWB: RegWrite=1, RegDst=1, MemtoReg=0.
REQ-031 IEXEC: ALUSrcA=1, ALUSrcB=10, ALUCtrl=0010, then IWB. IWB: RegWrite=1, RegDst=0, MemtoReg=0.
REQ-032 BRANCH: ALUSrcA=1, ALUSrcB=00, ALUCtrl=0110, PCSource=1. PCSel=Zero is the only combinational dependence on Zero.
REQ-033 Terminal states are MEMWB, MEMWR, RWB, IWB and BRANCH. Each goes to FETCH if run=1, else IDLE. Dropping run mid-instruction never aborts that instruction.
REQ-034 Instruction latencies from FETCH to the terminal state inclusive: lw 5, sw 4, R-type 4, addi 4, beq 3 cycles.
REQ-035 instr_count increments by 1 in each terminal-state cycle and saturates at all-ones.
REQ-036 HALT is left only by reset; halted=1 there and all control outputs are 0.
REQ-037 MemRead and MemWrite are never both 1. PCSel=1 only in FETCH or BRANCH.

Reset
REQ-038 reset=1 at a clk edge forces state=IDLE and instr_count=0, overriding any state, including mid-instruction and HALT. All outputs are 0 in the following cycle.
REQ-039 The first FETCH occurs no earlier than the first clk edge after reset deasserts with run=1.

Structure
REQ-040 Shared package multicycle_pkg holds the state enumeration, opcode constants, funct constants and ALUCtrl codes.
REQ-041 One sub-module, alu_control, maps funct to ALUCtrl plus a legal flag; DECODE uses the legal flag for HALT selection.

Verification
REQ-042 Reset with run=1, Op=0x23 -> states IDLE, FETCH, DECODE, MEMADR, MEMRD, MEMWB, FETCH; instr_count=1; MemtoReg=1 only in MEMWB.
REQ-043 Op=0x00, Function=0x2A -> ALUCtrl=0111 in REXEC; RegWrite=1 and RegDst=1 in RWB; 4-cycle latency.
REQ-044 Op=0x04 with Zero=1, then Zero=0 -> PCSel=1 and PCSource=1 in BRANCH for the first; PCSel=0 for the second.
REQ-045 Op=0x3F -> HALT after DECODE; halted=1 for 20 cycles regardless of run; reset returns to IDLE.
REQ-046 run deasserted during MEMWR of a sw -> MemWrite pulses once, then IDLE. run reasserted -> FETCH on the next edge.
REQ-047 reset asserted during REXEC -> IDLE next cycle with RegWrite=0 and instr_count=0; count saturation checked with CNT_W=4 after 20 instructions -> 15.

Source files
------------

// File: rtl/multicycle_controller_pkg.sv
// -----------------------------------------------------------------------------
// multicycle_pkg
// Shared definitions for the multicycle controller: FSM state encoding,
// opcode/funct constants, ALU control codes, the bundled control-word struct
// and a helper that identifies the states in which an instruction retires.
// -----------------------------------------------------------------------------
package multicycle_pkg;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_REXEC  = 4'd7,
    S_RWB    = 4'd8,
    S_BRANCH = 4'd9,
    S_IEXEC  = 4'd10,
    S_IWB    = 4'd11,
    S_HALT   = 4'd12
  } state_t;

  // Opcodes
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type funct codes
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_NOR = 6'h27;
  localparam logic [5:0] FN_SLT = 6'h2A;

  // ALU control codes
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  // All datapath control lines for one cycle.
  typedef struct packed {
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       ir_write;
    logic       pc_source;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       reg_write;
    logic       reg_dst;
    logic       pc_sel;
    logic [3:0] alu_ctrl;
  } ctrl_t;

  // States in which an instruction completes and the retire counter advances.
  function automatic logic is_terminal(input state_t s);
    return (s == S_MEMWB) || (s == S_MEMWR) || (s == S_RWB) ||
           (s == S_IWB)   || (s == S_BRANCH);
  endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// -----------------------------------------------------------------------------
// multicycle_controller_if
// Controller <-> datapath bundle. The datapath supplies the instruction
// fields (Op, Function) and the ALU Zero flag; the controller drives every
// datapath control line.
//   master : controller side (drives controls, reads Op/Function/Zero)
//   slave  : datapath side
// -----------------------------------------------------------------------------
interface multicycle_controller_if;
  logic [5:0] Op;
  logic [5:0] Function;
  logic       Zero;

  logic       IorD;
  logic       MemRead;
  logic       MemWrite;
  logic       MemtoReg;
  logic       IRWrite;
  logic       PCSource;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic       RegWrite;
  logic       RegDst;
  logic       PCSel;
  logic [3:0] ALUCtrl;

  modport master (
    input  Op, Function, Zero,
    output IorD, MemRead, MemWrite, MemtoReg, IRWrite, PCSource,
           ALUSrcA, ALUSrcB, RegWrite, RegDst, PCSel, ALUCtrl
  );

  modport slave (
    output Op, Function, Zero,
    input  IorD, MemRead, MemWrite, MemtoReg, IRWrite, PCSource,
           ALUSrcA, ALUSrcB, RegWrite, RegDst, PCSel, ALUCtrl
  );
endinterface

// File: rtl/multicycle_controller_alu_control.sv
// -----------------------------------------------------------------------------
// alu_control
// Maps an R-type funct field to its ALU control code and flags whether the
// funct is one the controller supports.
//   funct    : instruction funct field
//   alu_ctrl : ALU operation code (0 when funct is not supported)
//   legal    : 1 when funct is supported
// -----------------------------------------------------------------------------
module alu_control
  import multicycle_pkg::*;
(
  input  logic [5:0] funct,
  output logic [3:0] alu_ctrl,
  output logic       legal
);

  // NOTE: every output gets a default before the case so no path leaves a
  // value unassigned, which would otherwise infer a latch.
  always_comb begin
    alu_ctrl = ALU_AND;
    legal    = 1'b1;
    case (funct)
      FN_ADD:  alu_ctrl = ALU_ADD;
      FN_SUB:  alu_ctrl = ALU_SUB;
      FN_AND:  alu_ctrl = ALU_AND;
      FN_OR:   alu_ctrl = ALU_OR;
      FN_SLT:  alu_ctrl = ALU_SLT;
      FN_NOR:  alu_ctrl = ALU_NOR;
      default: legal    = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// -----------------------------------------------------------------------------
// multicycle_controller
// Control FSM for a multicycle MIPS-style datapath supporting lw, sw,
// R-type (add/sub/and/or/slt/nor), beq and addi. Unknown opcodes or funct
// codes park the FSM in HALT until reset. Controls are decoded from the
// registered state; only PCSel in BRANCH also looks at Zero.
//   clk         : clock, rising-edge
//   reset       : synchronous active-high reset
//   run         : level enable; new instructions start only while high
//   bus         : controller side of multicycle_controller_if
//   halted      : high while in HALT
//   state       : current state encoding (debug)
//   instr_count : saturating retired-instruction counter
// -----------------------------------------------------------------------------
module multicycle_controller
  import multicycle_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     run,
  multicycle_controller_if.master  bus,
  output logic                     halted,
  output logic [3:0]               state,
  output logic [CNT_W-1:0]         instr_count
);

  state_t           state_q, state_d;
  ctrl_t            ctrl;
  logic [3:0]       fn_alu_ctrl;
  logic             fn_legal;
  logic [CNT_W-1:0] count_q;

  alu_control u_alu_control (
    .funct    (bus.Function),
    .alu_ctrl (fn_alu_ctrl),
    .legal    (fn_legal)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of block ordering.
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    ctrl    = '0;
    halted  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (run) state_d = S_FETCH;
      end

      // Read instruction at PC, latch it, and write PC+1 back to PC.
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.ir_write  = 1'b1;
        ctrl.alu_src_b = 2'b01;
        ctrl.alu_ctrl  = ALU_ADD;
        ctrl.pc_sel    = 1'b1;
        state_d        = S_DECODE;
      end

      // PC already holds PC+1, so ALUOut captures the branch target.
      S_DECODE: begin
        ctrl.alu_src_b = 2'b10;
        ctrl.alu_ctrl  = ALU_ADD;
        case (bus.Op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = fn_legal ? S_REXEC : S_HALT;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_IEXEC;
          default:      state_d = S_HALT;
        endcase
      end

      S_MEMADR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = 2'b10;
        ctrl.alu_ctrl  = ALU_ADD;
        state_d        = (bus.Op == OP_LW) ? S_MEMRD : S_MEMWR;
      end

      S_MEMRD: begin
        ctrl.mem_read = 1'b1;
        ctrl.iord     = 1'b1;
        state_d       = S_MEMWB;
      end

      S_MEMWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        state_d         = run ? S_FETCH : S_IDLE;
      end

      S_MEMWR: begin
        ctrl.mem_write = 1'b1;
        ctrl.iord      = 1'b1;
        state_d        = run ? S_FETCH : S_IDLE;
      end

      S_REXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_ctrl  = fn_alu_ctrl;
        state_d        = S_RWB;
      end

      S_RWB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
        state_d        = run ? S_FETCH : S_IDLE;
      end

      // Compare A and B; take the branch target held in ALUOut when equal.
      S_BRANCH: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_ctrl  = ALU_SUB;
        ctrl.pc_source = 1'b1;
        ctrl.pc_sel    = bus.Zero;
        state_d        = run ? S_FETCH : S_IDLE;
      end

      S_IEXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = 2'b10;
        ctrl.alu_ctrl  = ALU_ADD;
        state_d        = S_IWB;
      end

      S_IWB: begin
        ctrl.reg_write = 1'b1;
        state_d        = run ? S_FETCH : S_IDLE;
      end

      // Only reset leaves HALT.
      S_HALT: begin
        halted = 1'b1;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // Retire counter: one count per terminal-state cycle, sticks at all-ones.
  always_ff @(posedge clk) begin
    if (reset)
      count_q <= '0;
    else if (is_terminal(state_q) && (count_q != '1))
      count_q <= count_q + CNT_W'(1);
  end

  assign state       = state_q;
  assign instr_count = count_q;

  assign bus.IorD     = ctrl.iord;
  assign bus.MemRead  = ctrl.mem_read;
  assign bus.MemWrite = ctrl.mem_write;
  assign bus.MemtoReg = ctrl.mem_to_reg;
  assign bus.IRWrite  = ctrl.ir_write;
  assign bus.PCSource = ctrl.pc_source;
  assign bus.ALUSrcA  = ctrl.alu_src_a;
  assign bus.ALUSrcB  = ctrl.alu_src_b;
  assign bus.RegWrite = ctrl.reg_write;
  assign bus.RegDst   = ctrl.reg_dst;
  assign bus.PCSel    = ctrl.pc_sel;
  assign bus.ALUCtrl  = ctrl.alu_ctrl;

endmodule

// File: tb/tb_multicycle_controller.sv
// -----------------------------------------------------------------------------
// tb_multicycle_controller
// Directed stimulus for the multicycle controller. Each stimulus cycle pushes
// the hand-derived expected state/controls/count for that cycle into a queue;
// a monitor on the falling edge pops and compares. A second instance with a
// 4-bit counter shares all inputs to exercise counter saturation.
// -----------------------------------------------------------------------------
module tb_multicycle_controller;
  import multicycle_pkg::*;

  logic clk = 1'b0;
  logic reset;
  logic run;
  always #5 clk = ~clk;

  multicycle_controller_if bus ();
  multicycle_controller_if bus4 ();

  assign bus4.Op       = bus.Op;
  assign bus4.Function = bus.Function;
  assign bus4.Zero     = bus.Zero;

  logic        halted, halted4;
  logic [3:0]  state, state4;
  logic [15:0] instr_count;
  logic [3:0]  instr_count4;

  multicycle_controller dut (
    .clk         (clk),
    .reset       (reset),
    .run         (run),
    .bus         (bus),
    .halted      (halted),
    .state       (state),
    .instr_count (instr_count)
  );

  multicycle_controller #(.CNT_W(4)) dut4 (
    .clk         (clk),
    .reset       (reset),
    .run         (run),
    .bus         (bus4),
    .halted      (halted4),
    .state       (state4),
    .instr_count (instr_count4)
  );

  typedef struct {
    state_t      st;
    ctrl_t       c;
    logic [15:0] cnt;
    logic [3:0]  cnt4;
    logic        halt;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [15:0] cnt_m    = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // Hand-specified control word builder.
  function automatic ctrl_t cv(input logic iord, input logic mr, input logic mw,
                               input logic m2r, input logic irw, input logic pcs,
                               input logic sa, input logic [1:0] sb_, input logic rw,
                               input logic rd, input logic psel, input logic [3:0] alu);
    ctrl_t c;
    c.iord = iord; c.mem_read = mr; c.mem_write = mw; c.mem_to_reg = m2r;
    c.ir_write = irw; c.pc_source = pcs; c.alu_src_a = sa; c.alu_src_b = sb_;
    c.reg_write = rw; c.reg_dst = rd; c.pc_sel = psel; c.alu_ctrl = alu;
    return c;
  endfunction

  function automatic ctrl_t e_none();   return '0; endfunction
  function automatic ctrl_t e_fetch();  return cv(0,1,0,0,1,0,0,2'b01,0,0,1,4'b0010); endfunction
  function automatic ctrl_t e_decode(); return cv(0,0,0,0,0,0,0,2'b10,0,0,0,4'b0010); endfunction
  function automatic ctrl_t e_memadr(); return cv(0,0,0,0,0,0,1,2'b10,0,0,0,4'b0010); endfunction
  function automatic ctrl_t e_memrd();  return cv(1,1,0,0,0,0,0,2'b00,0,0,0,4'b0000); endfunction
  function automatic ctrl_t e_memwb();  return cv(0,0,0,1,0,0,0,2'b00,1,0,0,4'b0000); endfunction
  function automatic ctrl_t e_memwr();  return cv(1,0,1,0,0,0,0,2'b00,0,0,0,4'b0000); endfunction
  function automatic ctrl_t e_rexec(input logic [3:0] alu);
    return cv(0,0,0,0,0,0,1,2'b00,0,0,0,alu);
  endfunction
  function automatic ctrl_t e_rwb();    return cv(0,0,0,0,0,0,0,2'b00,1,1,0,4'b0000); endfunction
  function automatic ctrl_t e_iexec();  return cv(0,0,0,0,0,0,1,2'b10,0,0,0,4'b0010); endfunction
  function automatic ctrl_t e_iwb();    return cv(0,0,0,0,0,0,0,2'b00,1,0,0,4'b0000); endfunction
  function automatic ctrl_t e_branch(input logic z);
    return cv(0,0,0,0,0,1,1,2'b00,0,0,z,4'b0110);
  endfunction

  // One stimulus cycle: drive reset/run, record what this cycle must show,
  // then advance to just after the next rising edge.
  task automatic tick(input logic rs, input logic rn, input state_t st,
                      input ctrl_t c, input logic term, input logic h);
    exp_t e;
    reset  = rs;
    run    = rn;
    e.st   = st;
    e.c    = c;
    e.cnt  = cnt_m;
    e.cnt4 = (cnt_m > 16'd15) ? 4'hF : cnt_m[3:0];
    e.halt = h;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (rs)        cnt_m = '0;
    else if (term) cnt_m = cnt_m + 16'd1;
  endtask

  task automatic do_lw(input logic run_last);
    bus.Op = OP_LW;
    tick(0, 1, S_FETCH,  e_fetch(),  0, 0);
    tick(0, 1, S_DECODE, e_decode(), 0, 0);
    tick(0, 1, S_MEMADR, e_memadr(), 0, 0);
    tick(0, 1, S_MEMRD,  e_memrd(),  0, 0);
    tick(0, run_last, S_MEMWB, e_memwb(), 1, 0);
  endtask

  task automatic do_rtype(input logic [5:0] fn, input logic [3:0] alu);
    bus.Op = OP_RTYPE;
    bus.Function = fn;
    tick(0, 1, S_FETCH,  e_fetch(),    0, 0);
    tick(0, 1, S_DECODE, e_decode(),   0, 0);
    tick(0, 1, S_REXEC,  e_rexec(alu), 0, 0);
    tick(0, 1, S_RWB,    e_rwb(),      1, 0);
  endtask

  task automatic do_beq(input logic z);
    bus.Op = OP_BEQ;
    bus.Zero = z;
    tick(0, 1, S_FETCH,  e_fetch(),    0, 0);
    tick(0, 1, S_DECODE, e_decode(),   0, 0);
    tick(0, 1, S_BRANCH, e_branch(z),  1, 0);
  endtask

  task automatic do_addi(input logic run_last);
    bus.Op = OP_ADDI;
    tick(0, 1, S_FETCH,  e_fetch(),  0, 0);
    tick(0, 1, S_DECODE, e_decode(), 0, 0);
    tick(0, 1, S_IEXEC,  e_iexec(),  0, 0);
    tick(0, run_last, S_IWB, e_iwb(), 1, 0);
  endtask

  // Monitor: compares every cycle that has a pending expectation.
  always @(negedge clk) begin
    if (sb.size() != 0) begin
      exp_t  e;
      ctrl_t a;
      e = sb.pop_front();
      a.iord = bus.IorD; a.mem_read = bus.MemRead; a.mem_write = bus.MemWrite;
      a.mem_to_reg = bus.MemtoReg; a.ir_write = bus.IRWrite; a.pc_source = bus.PCSource;
      a.alu_src_a = bus.ALUSrcA; a.alu_src_b = bus.ALUSrcB; a.reg_write = bus.RegWrite;
      a.reg_dst = bus.RegDst; a.pc_sel = bus.PCSel; a.alu_ctrl = bus.ALUCtrl;
      check($sformatf("state(%s)", e.st.name()), 32'(state), 32'(e.st));
      check($sformatf("ctrl(%s)", e.st.name()), 32'(a), 32'(e.c));
      check("halted", 32'(halted), 32'(e.halt));
      check("instr_count", 32'(instr_count), 32'(e.cnt));
      check("instr_count_w4", 32'(instr_count4), 32'(e.cnt4));
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    reset        = 1'b1;
    run          = 1'b1;
    bus.Op       = OP_LW;
    bus.Function = 6'h00;
    bus.Zero     = 1'b0;
    @(posedge clk);
    #1;

    // Reset held, then released with run=1: first FETCH one edge later.
    tick(1, 1, S_IDLE, e_none(), 0, 0);
    tick(0, 1, S_IDLE, e_none(), 0, 0);

    // lw, then every supported R-type funct.
    do_lw(1);
    do_rtype(FN_SLT, 4'b0111);
    do_rtype(FN_ADD, 4'b0010);
    do_rtype(FN_SUB, 4'b0110);
    do_rtype(FN_AND, 4'b0000);
    do_rtype(FN_OR,  4'b0001);
    do_rtype(FN_NOR, 4'b1100);

    // beq taken / not taken, addi.
    do_beq(1'b1);
    do_beq(1'b0);
    bus.Zero = 1'b0;
    do_addi(1);

    // sw with run dropped in MEMWR: single MemWrite pulse, then IDLE.
    bus.Op = OP_SW;
    tick(0, 1, S_FETCH,  e_fetch(),  0, 0);
    tick(0, 1, S_DECODE, e_decode(), 0, 0);
    tick(0, 1, S_MEMADR, e_memadr(), 0, 0);
    tick(0, 0, S_MEMWR,  e_memwr(),  1, 0);
    tick(0, 0, S_IDLE,   e_none(),   0, 0);
    tick(0, 1, S_IDLE,   e_none(),   0, 0);

    // Reset during REXEC: IDLE next with no register write and count cleared.
    bus.Op = OP_RTYPE;
    bus.Function = FN_ADD;
    tick(0, 1, S_FETCH,  e_fetch(),         0, 0);
    tick(0, 1, S_DECODE, e_decode(),        0, 0);
    tick(1, 1, S_REXEC,  e_rexec(4'b0010),  0, 0);
    tick(0, 1, S_IDLE,   e_none(),          0, 0);

    // 20 back-to-back addi: 16-bit count reaches 20, 4-bit count sticks at 15.
    for (int i = 0; i < 20; i++) do_addi(i != 19);
    tick(0, 1, S_IDLE, e_none(), 0, 0);

    // Illegal funct in an R-type goes to HALT.
    bus.Op = OP_RTYPE;
    bus.Function = 6'h3F;
    tick(0, 1, S_FETCH,  e_fetch(),  0, 0);
    tick(0, 1, S_DECODE, e_decode(), 0, 0);
    tick(1, 1, S_HALT,   e_none(),   0, 1);
    tick(0, 1, S_IDLE,   e_none(),   0, 0);

    // Illegal opcode: HALT for 20 cycles regardless of run, reset recovers.
    bus.Op = 6'h3F;
    bus.Function = FN_ADD;
    tick(0, 1, S_FETCH,  e_fetch(),  0, 0);
    tick(0, 1, S_DECODE, e_decode(), 0, 0);
    for (int i = 0; i < 20; i++) tick(0, logic'(i[0]), S_HALT, e_none(), 0, 1);
    tick(1, 1, S_HALT, e_none(), 0, 1);
    tick(0, 0, S_IDLE, e_none(), 0, 0);
    tick(0, 0, S_IDLE, e_none(), 0, 0);

    for (int i = 0; i < 5 && sb.size() != 0; i++) @(negedge clk);
    #1;
    check("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
